// File: rtl/nand_seq_pkg.sv
// Shared types and constants for the NAND operation sequencer: state encoding,
// phase codes, toggle-block pin vectors and the per-phase configuration helper.
package nand_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD1,
        S_ADDR,
        S_DATA,
        S_CMD2,
        S_RBWAIT,
        S_FIN
    } state_t;

    localparam logic [2:0] PH_IDLE   = 3'd0;
    localparam logic [2:0] PH_CMD1   = 3'd1;
    localparam logic [2:0] PH_ADDR   = 3'd2;
    localparam logic [2:0] PH_DATA   = 3'd3;
    localparam logic [2:0] PH_CMD2   = 3'd4;
    localparam logic [2:0] PH_RBWAIT = 3'd5;

    // Pin vector layout {RE_n, WE_n, ALE, CLE, CE_n}
    localparam int PIN_RE_N = 4;
    localparam int PIN_WE_N = 3;
    localparam int PIN_ALE  = 2;
    localparam int PIN_CLE  = 1;
    localparam int PIN_CE_N = 0;

    // Setup-side vectors; the hold side is the same pins with both strobes released.
    localparam logic [4:0] VEC_IDLE = 5'b11001;
    localparam logic [4:0] VEC_CMD  = 5'b10010;
    localparam logic [4:0] VEC_ADDR = 5'b10100;
    localparam logic [4:0] VEC_DWR  = 5'b10000;
    localparam logic [4:0] VEC_DRD  = 5'b01000;

    typedef struct packed {
        logic        cmd1_en;
        logic [2:0]  addr_cnt;
        logic [11:0] data_cnt;
        logic        data_rd;
        logic        cmd2_en;
        logic        wait_rb;
    } op_desc_t;

    typedef struct packed {
        logic [11:0] cnt;
        logic [4:0]  setup;
        logic [4:0]  hold;
        logic [2:0]  phase;
        logic        toggle;
    } phase_cfg_t;

    function automatic logic [4:0] hold_of(input logic [4:0] setup);
        logic [4:0] v;
        v = setup;
        v[PIN_RE_N] = 1'b1;
        v[PIN_WE_N] = 1'b1;
        return v;
    endfunction

    // First enabled phase strictly after cur, in the fixed operation order.
    function automatic state_t next_state(input state_t cur, input op_desc_t d);
        if (cur == S_IDLE && d.cmd1_en)
            return S_CMD1;
        if (cur inside {S_IDLE, S_CMD1} && d.addr_cnt != 3'd0)
            return S_ADDR;
        if (cur inside {S_IDLE, S_CMD1, S_ADDR} && d.data_cnt != 12'd0)
            return S_DATA;
        if (cur inside {S_IDLE, S_CMD1, S_ADDR, S_DATA} && d.cmd2_en)
            return S_CMD2;
        if (cur inside {S_IDLE, S_CMD1, S_ADDR, S_DATA, S_CMD2} && d.wait_rb)
            return S_RBWAIT;
        return S_FIN;
    endfunction

    function automatic phase_cfg_t phase_cfg(input state_t s, input op_desc_t d);
        phase_cfg_t c;
        c.cnt    = 12'd0;
        c.setup  = VEC_IDLE;
        c.phase  = PH_IDLE;
        c.toggle = 1'b0;
        case (s)
            S_CMD1: begin
                c.cnt = 12'd1; c.setup = VEC_CMD; c.phase = PH_CMD1; c.toggle = 1'b1;
            end
            S_ADDR: begin
                c.cnt = {9'd0, d.addr_cnt}; c.setup = VEC_ADDR; c.phase = PH_ADDR; c.toggle = 1'b1;
            end
            S_DATA: begin
                c.cnt    = d.data_cnt;
                c.setup  = d.data_rd ? VEC_DRD : VEC_DWR;
                c.phase  = PH_DATA;
                c.toggle = 1'b1;
            end
            S_CMD2: begin
                c.cnt = 12'd1; c.setup = VEC_CMD; c.phase = PH_CMD2; c.toggle = 1'b1;
            end
            S_RBWAIT: c.phase = PH_RBWAIT;
            default: ;
        endcase
        c.hold = hold_of(c.setup);
        return c;
    endfunction

endpackage

// File: rtl/nand_rb_wait.sv
// Ready/busy wait: synchronises rb_n, holds off for the tWB guard, then reports
// ready on rb_n high or timed_out after RB_TIMEOUT further cycles.
module nand_rb_wait #(
    parameter int WB_DLY     = 4,
    parameter int RB_TIMEOUT = 4095
) (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic rb_n,
    output logic ready,
    output logic timed_out
);

    localparam int GW = $clog2(WB_DLY + 2);
    localparam int TW = $clog2(RB_TIMEOUT + 2);

    logic          rb_meta, rb_sync;
    logic [GW-1:0] guard_cnt;
    logic [TW-1:0] to_cnt;
    logic          guard_done;

    assign guard_done = (guard_cnt == GW'(WB_DLY));
    assign ready      = go && guard_done && rb_sync;
    assign timed_out  = go && guard_done && !rb_sync && (to_cnt == TW'(RB_TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rb_meta   <= 1'b0;
            rb_sync   <= 1'b0;
            guard_cnt <= '0;
            to_cnt    <= '0;
        end else begin
            rb_meta <= rb_n;
            rb_sync <= rb_meta;
            // Counters only run while the sequencer sits in RBWAIT
            if (!go) begin
                guard_cnt <= '0;
                to_cnt    <= '0;
            end else if (!guard_done) begin
                guard_cnt <= guard_cnt + 1'b1;
            end else if (!ready && !timed_out) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nand_op_sequencer.sv
// Walks one NAND operation descriptor through CMD1/ADDR/DATA/CMD2/RBWAIT,
// programming the toggle pin-driver block for each phase.
module nand_op_sequencer
    import nand_seq_pkg::*;
#(
    parameter int WB_DLY     = 4,
    parameter int RB_TIMEOUT = 4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cmd1_en,
    input  logic [2:0]  addr_cnt,
    input  logic [11:0] data_cnt,
    input  logic        data_rd,
    input  logic        cmd2_en,
    input  logic        wait_rb,
    input  logic        rb_n,
    input  logic        tg_done,
    output logic        tg_enable,
    output logic [11:0] tg_cnt,
    output logic [4:0]  tg_setup,
    output logic [4:0]  tg_hold,
    output logic [2:0]  phase,
    output logic        busy,
    output logic        done,
    output logic        timeout
);

    state_t     state, nxt;
    logic       issue;
    op_desc_t   desc, in_desc, sel_desc;
    phase_cfg_t nxt_cfg;
    logic       adv;
    logic       rb_go, rb_ready, rb_to;

    assign in_desc = {cmd1_en, addr_cnt, data_cnt, data_rd, cmd2_en, wait_rb};
    assign rb_go   = (state == S_RBWAIT);

    // In IDLE the live inputs decide the first phase; afterwards the latched copy does.
    always_comb begin
        sel_desc = (state == S_IDLE) ? in_desc : desc;
        nxt      = next_state(state, sel_desc);
        nxt_cfg  = phase_cfg(nxt, sel_desc);
        adv      = 1'b0;
        case (state)
            S_IDLE:                         adv = start;
            S_CMD1, S_ADDR, S_DATA, S_CMD2: adv = !issue && tg_done;
            S_RBWAIT:                       adv = rb_ready || rb_to;
            default:                        adv = 1'b0;
        endcase
    end

    nand_rb_wait #(
        .WB_DLY     (WB_DLY),
        .RB_TIMEOUT (RB_TIMEOUT)
    ) u_rb_wait (
        .clk       (clk),
        .reset     (reset),
        .go        (rb_go),
        .rb_n      (rb_n),
        .ready     (rb_ready),
        .timed_out (rb_to)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            issue     <= 1'b0;
            desc      <= '0;
            tg_enable <= 1'b0;
            tg_cnt    <= 12'd0;
            tg_setup  <= VEC_IDLE;
            tg_hold   <= hold_of(VEC_IDLE);
            phase     <= PH_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            tg_enable <= 1'b0;
            done      <= 1'b0;
            issue     <= 1'b0;
            if (adv) begin
                state     <= nxt;
                issue     <= nxt_cfg.toggle;
                tg_enable <= nxt_cfg.toggle;
                tg_cnt    <= nxt_cfg.cnt;
                tg_setup  <= nxt_cfg.setup;
                tg_hold   <= nxt_cfg.hold;
                phase     <= nxt_cfg.phase;
                done      <= (nxt == S_FIN);
                if (state == S_IDLE) begin
                    desc    <= in_desc;
                    busy    <= 1'b1;
                    timeout <= 1'b0;
                end
                if (state == S_RBWAIT && !rb_ready)
                    timeout <= 1'b1;
            end else if (state == S_FIN) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Scoreboard bench for nand_op_sequencer: expected toggle-block programmings are
// queued per operation and popped as tg_enable pulses appear.
module tb_nand_op_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, cmd1_en, data_rd, cmd2_en, wait_rb, rb_n, tg_done;
    logic [2:0]  addr_cnt;
    logic [11:0] data_cnt;
    logic        tg_enable, busy, done, timeout;
    logic [11:0] tg_cnt;
    logic [4:0]  tg_setup, tg_hold;
    logic [2:0]  phase;

    typedef struct packed {
        logic [11:0] cnt;
        logic [4:0]  setup;
        logic [4:0]  hold;
        logic [2:0]  ph;
    } tg_exp_t;

    tg_exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nand_op_sequencer #(.WB_DLY(4), .RB_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd1_en(cmd1_en), .addr_cnt(addr_cnt),
        .data_cnt(data_cnt), .data_rd(data_rd), .cmd2_en(cmd2_en), .wait_rb(wait_rb),
        .rb_n(rb_n), .tg_done(tg_done), .tg_enable(tg_enable), .tg_cnt(tg_cnt),
        .tg_setup(tg_setup), .tg_hold(tg_hold), .phase(phase), .busy(busy),
        .done(done), .timeout(timeout)
    );

    // Runs one operation, answering tg_done 3 cycles after each tg_enable.
    task automatic run_op(input logic c1, input logic [2:0] ac, input logic [11:0] dc,
                          input logic rd, input logic c2, input logic wr, input int rb_rise,
                          input bit mid_start, input string name,
                          output int n_en, output int n_done, output int done_cyc,
                          output int rb_cycles, output logic to_at_done);
        tg_exp_t e, cur;
        int dly, rb_cnt, ph5_first;
        bit fin, mid_done;
        cur = '0;
        @(negedge clk);
        cmd1_en = c1; addr_cnt = ac; data_cnt = dc; data_rd = rd; cmd2_en = c2; wait_rb = wr;
        rb_n = !wr;
        start = 1'b1;
        @(negedge clk);
        cmd1_en = !c1; addr_cnt = ~ac; data_cnt = ~dc; data_rd = !rd; cmd2_en = !c2; wait_rb = !wr;
        n_en = 0; n_done = 0; done_cyc = -1; rb_cycles = -1; to_at_done = 1'bx;
        dly = -1; rb_cnt = -1; ph5_first = -1; fin = 0; mid_done = 0;
        for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
            start = 1'b0;
            tg_done = 1'b0;
            if (tg_enable) begin
                n_en++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s unexpected_tg_enable got cnt=%0d setup=%b hold=%b phase=%0d want none",
                             name, tg_cnt, tg_setup, tg_hold, phase);
                end else begin
                    e = exp_q.pop_front();
                    cur = e;
                    if ({tg_cnt, tg_setup, tg_hold, phase} !== e) begin
                        failures++;
                        $display("FAIL %s tg_program got cnt=%0d setup=%b hold=%b phase=%0d want cnt=%0d setup=%b hold=%b phase=%0d",
                                 name, tg_cnt, tg_setup, tg_hold, phase, e.cnt, e.setup, e.hold, e.ph);
                    end
                end
                dly = 3;
                if (phase == 3'd4 && rb_rise > 0) rb_cnt = rb_rise;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    tg_done = 1'b1;
                    checks++;
                    if ({tg_cnt, tg_setup, tg_hold, phase} !== cur) begin
                        failures++;
                        $display("FAIL %s wait_hold got cnt=%0d setup=%b hold=%b phase=%0d want cnt=%0d setup=%b hold=%b phase=%0d",
                                 name, tg_cnt, tg_setup, tg_hold, phase, cur.cnt, cur.setup, cur.hold, cur.ph);
                    end
                end
            end
            if (rb_cnt > 0) begin
                rb_cnt--;
                if (rb_cnt == 0) rb_n = 1'b1;
            end
            if (phase == 3'd5 && ph5_first < 0) ph5_first = cyc;
            if (mid_start && phase == 3'd3 && !mid_done) begin
                start = 1'b1; cmd1_en = 1'b1; addr_cnt = 3'd7; data_cnt = 12'd9; cmd2_en = 1'b1;
                mid_done = 1;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                to_at_done = timeout;
                if (ph5_first >= 0) rb_cycles = cyc - ph5_first;
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s busy_at_done got %b want 1", name, busy);
                end
                fin = 1;
            end
            @(negedge clk);
        end
        tg_done = 1'b0;
        start = 1'b0;
        checks++;
        if (!fin) begin
            failures++;
            $display("FAIL %s done_budget got no done want done within 300 cycles", name);
        end else if ({busy, done, phase, tg_setup, tg_hold} !== {1'b0, 1'b0, 3'd0, 5'b11001, 5'b11001}) begin
            failures++;
            $display("FAIL %s post_idle got busy=%b done=%b phase=%0d setup=%b hold=%b want 0 0 0 11001 11001",
                     name, busy, done, phase, tg_setup, tg_hold);
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing_tg_enable got %0d left want 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 0; cmd1_en = 0; addr_cnt = 0; data_cnt = 0; data_rd = 0;
        cmd2_en = 0; wait_rb = 0; rb_n = 1; tg_done = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tg_enable, tg_cnt, tg_setup, tg_hold, phase, busy, done, timeout} !==
            {1'b0, 12'd0, 5'b11001, 5'b11001, 3'd0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got en=%b cnt=%0d setup=%b hold=%b phase=%0d busy=%b done=%b to=%b want 0 0 11001 11001 0 0 0 0",
                     tg_enable, tg_cnt, tg_setup, tg_hold, phase, busy, done, timeout);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_page_read;
        int n_en, n_done, dc, rbc;
        logic to;
        exp_q.push_back({12'd1, 5'b10010, 5'b11010, 3'd1});
        exp_q.push_back({12'd5, 5'b10100, 5'b11100, 3'd2});
        exp_q.push_back({12'd1, 5'b10010, 5'b11010, 3'd4});
        run_op(1, 3'd5, 12'd0, 1, 1, 1, 20, 0, "page_read", n_en, n_done, dc, rbc, to);
        checks++;
        if ({n_en, n_done} !== {32'd3, 32'd1} || to !== 1'b0) begin
            failures++;
            $display("FAIL page_read counts got en=%0d done=%0d timeout=%b want 3 1 0", n_en, n_done, to);
        end
    endtask

    task automatic test_write;
        int n_en, n_done, dc, rbc;
        logic to;
        exp_q.push_back({12'd1, 5'b10010, 5'b11010, 3'd1});
        exp_q.push_back({12'd2, 5'b10100, 5'b11100, 3'd2});
        exp_q.push_back({12'd4, 5'b10000, 5'b11000, 3'd3});
        run_op(1, 3'd2, 12'd4, 0, 0, 0, -1, 0, "write", n_en, n_done, dc, rbc, to);
        checks++;
        if ({n_en, n_done} !== {32'd3, 32'd1} || to !== 1'b0) begin
            failures++;
            $display("FAIL write counts got en=%0d done=%0d timeout=%b want 3 1 0", n_en, n_done, to);
        end
    endtask

    // Also pulses start mid-DATA with a different descriptor, which must be ignored.
    task automatic test_read_data_mid_start;
        int n_en, n_done, dc, rbc;
        logic to;
        exp_q.push_back({12'd4095, 5'b01000, 5'b11000, 3'd3});
        run_op(0, 3'd0, 12'd4095, 1, 0, 0, -1, 1, "read_data", n_en, n_done, dc, rbc, to);
        checks++;
        if ({n_en, n_done} !== {32'd1, 32'd1}) begin
            failures++;
            $display("FAIL read_data counts got en=%0d done=%0d want 1 1", n_en, n_done);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tg_enable !== 1'b0) begin
            failures++;
            $display("FAIL mid_start_ignored got busy=%b en=%b want 0 0", busy, tg_enable);
        end
    endtask

    task automatic test_rb_timeout;
        int n_en, n_done, dc, rbc;
        logic to;
        run_op(0, 3'd0, 12'd0, 0, 0, 1, -1, 0, "rb_timeout", n_en, n_done, dc, rbc, to);
        checks++;
        if (to !== 1'b1 || n_done != 1 || n_en != 0) begin
            failures++;
            $display("FAIL rb_timeout flag got timeout=%b done=%0d en=%0d want 1 1 0", to, n_done, n_en);
        end
        checks++;
        if (rbc < 21 || rbc > 23) begin
            failures++;
            $display("FAIL rb_timeout cycles got %0d want 21..23", rbc);
        end
        checks++;
        if (timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky got %b want 1", timeout);
        end
        // Empty descriptor: done on the first cycle after start, no toggles, timeout cleared
        run_op(0, 3'd0, 12'd0, 0, 0, 0, -1, 0, "empty", n_en, n_done, dc, rbc, to);
        checks++;
        if (dc != 0 || n_en != 0 || to !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL empty_op got done_cyc=%0d en=%0d timeout=%b/%b want 0 0 0/0", dc, n_en, to, timeout);
        end
        rb_n = 1'b1;
    endtask

    task automatic test_spurious_done;
        bit bad = 0;
        @(negedge clk);
        tg_done = 1'b1;
        @(negedge clk);
        tg_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy !== 1'b0 || tg_enable !== 1'b0 || done !== 1'b0 || phase !== 3'd0) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL spurious_done_idle got activity want none busy=%b phase=%0d", busy, phase);
        end
    endtask

    task automatic test_reset_mid;
        int dly = -1;
        bit hit = 0;
        bit bad = 0;
        @(negedge clk);
        cmd1_en = 1; addr_cnt = 3'd5; data_cnt = 12'd0; data_rd = 1; cmd2_en = 1; wait_rb = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            tg_done = 1'b0;
            if (phase == 3'd2 && !tg_enable && busy) hit = 1;
            else begin
                if (tg_enable) dly = 3;
                else if (dly > 0) begin dly--; if (dly == 0) tg_done = 1'b1; end
                @(negedge clk);
            end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL reset_mid reach_addr_wait got phase=%0d want 2", phase);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({tg_enable, tg_cnt, tg_setup, tg_hold, phase, busy, done, timeout} !==
            {1'b0, 12'd0, 5'b11001, 5'b11001, 3'd0, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid values got en=%b cnt=%0d setup=%b hold=%b phase=%0d busy=%b done=%b want 0 0 11001 11001 0 0 0",
                     tg_enable, tg_cnt, tg_setup, tg_hold, phase, busy, done);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        tg_done = 1'b1;
        @(negedge clk);
        tg_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (tg_enable !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad = 1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_mid late_tg_done got activity want none");
        end
    endtask

    initial begin
        test_reset();
        test_page_read();
        test_write();
        test_read_data_mid_start();
        test_rb_timeout();
        test_spurious_done();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nand_op_sequencer.md
Name: nand_op_sequencer

Overview:
- Sequences one complete NAND flash operation through the toggle pin-driver block: command-1 latch, address cycles, data cycles (write or read), command-2 latch, then a wait on ready/busy.
- Accepts one operation descriptor per start pulse.
- For each phase it programs the toggle block's count and setup/hold pin vectors, fires a one-cycle enable, then waits for that block's done.
- Sits between the flash host-side controller and the toggle block; its phase output steers the DQ data mux.

Parameters:
- WB_DLY, 4: cycles after the last phase before rb_n is sampled (tWB guard).
- RB_TIMEOUT, 4095: maximum cycles to wait for rb_n high before flagging timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- cmd1_en  in  1  issue command-1 cycle.
- addr_cnt  in  3  number of address cycles, 0-7.
- data_cnt  in  12  number of data cycles, 0-4095.
- data_rd  in  1  1 = read data (RE_n toggles), 0 = write data (WE_n toggles).
- cmd2_en  in  1  issue command-2 cycle.
- wait_rb  in  1  wait for rb_n high after the last phase.
- rb_n  in  1  flash ready/busy, asynchronous.
- tg_done  in  1  toggle block completion pulse.
- tg_enable  out  1  one-cycle start to the toggle block.
- tg_cnt  out  12  cycle count to the toggle block.
- tg_setup  out  5  setup pin vector.
- tg_hold  out  5  hold pin vector.
- phase  out  3  current phase code (DQ mux select).
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  sticky; set on rb_n timeout, cleared by the next accepted start.

Behaviour:
- Pin vector bit order is {RE_n, WE_n, ALE, CLE, CE_n}.
- Vectors per phase, as setup/hold:
  - IDLE: 11001/11001.
  - CMD: 10010/11010.
  - ADDR: 10100/11100.
  - DWR: 10000/11000.
  - DRD: 01000/11000.
- Reset / IDLE output values:
  - tg_enable=0, tg_cnt=0, tg_setup/tg_hold=IDLE vector, phase=0, busy=0, done=0, timeout=0.
  - State returns to IDLE and the rb synchroniser clears.
- States: IDLE, CMD1, ADDR, DATA, CMD2, RBWAIT, FIN. Each toggle phase has two sub-steps:
  - ISSUE: tg_enable=1 for exactly one cycle; vectors and tg_cnt valid the same cycle.
  - WAIT: vectors and tg_cnt held stable until tg_done.
- Start acceptance:
  - start in IDLE latches all descriptor fields, sets busy, and clears timeout.
  - Next cycle enters the first enabled phase in ISSUE.
  - start while busy is ignored.
- Phase order is CMD1 -> ADDR -> DATA -> CMD2 -> RBWAIT. A phase is skipped when its enable is 0 or its count is 0.
- Counts per phase: CMD phases use tg_cnt=1, ADDR uses addr_cnt (zero-extended), DATA uses data_cnt.
- Phase codes: 0 idle, 1 cmd1, 2 addr, 3 data, 4 cmd2, 5 rbwait.
- tg_done handling:
  - In WAIT, tg_done moves to the next phase's ISSUE on the following cycle.
  - tg_done in any other state is ignored.
- RBWAIT:
  - rb_n passes through a 2-flop synchroniser.
  - Counts WB_DLY cycles, then exits when the synchronised rb_n is 1.
  - If RB_TIMEOUT cycles elapse after the guard, sets timeout and exits.
- FIN: done=1 for one cycle with busy still 1. Next cycle returns to IDLE with busy=0.
- Empty descriptor (all enables 0 or counts 0, wait_rb=0): start -> FIN next cycle -> done. No tg_enable is issued.
- Reset mid-operation aborts immediately with no done. A later tg_done is ignored.

Decomposition:
- Package nand_seq_pkg holds:
  - state enum;
  - phase code constants;
  - the five pin-vector constants;
  - bit-index constants for RE_n/WE_n/ALE/CLE/CE_n.
- One sub-module, nand_rb_wait: rb_n synchroniser, WB_DLY guard counter, timeout counter. Interface is go in; ready, timed_out out.

Test Plan:
- Page-read setup (cmd1_en=1, addr_cnt=5, data_cnt=0, cmd2_en=1, wait_rb=1; bench answers tg_done 3 cycles after each tg_enable; rb_n rises 20 cycles after CMD2):
  - exactly 3 tg_enable pulses with tg_cnt 1, 5, 1;
  - vectors 10010/11010, 10100/11100, 10010/11010;
  - done once; timeout=0.
- Write (cmd1_en=1, addr_cnt=2, data_cnt=4, data_rd=0): tg_enable pulses carry tg_cnt=1, 2, 4; DATA phase shows 10000/11000 and phase=3; done after the third tg_done.
- Read data only (data_cnt=4095, data_rd=1): single tg_enable with tg_cnt=4095, vectors 01000/11000.
- rb_n held low with wait_rb=1 and RB_TIMEOUT=16: timeout=1 and done after 4+2+16 cycles of RBWAIT (±1); the next start clears timeout.
- Simultaneous events:
  - start pulsed during DATA: ignored, descriptor unchanged.
  - spurious tg_done in IDLE: no state change.
- Reset during ADDR WAIT: outputs return to reset values the same cycle; no done; a later tg_done has no effect.
